// File: rtl/flipflop_register_multimode.sv
// Multi-mode register bank: each cycle the whole word holds, loads, toggles,
// updates as JK, counts up/down or shifts left, with wrap and change status.
module flipflop_register_multimode #(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] t,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic             tc,
  output logic             changed
);

  typedef enum logic [2:0] {
    MODE_HOLD     = 3'b000,
    MODE_LOAD     = 3'b001,
    MODE_TOGGLE   = 3'b010,
    MODE_JK       = 3'b011,
    MODE_UP       = 3'b100,
    MODE_DOWN     = 3'b101,
    MODE_SHIFT    = 3'b110,
    MODE_RESERVED = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic             wrap;

  // Unknown en or mode falls through to the hold defaults, so no status pulses.
  always_comb begin
    q_next = q;
    wrap   = 1'b0;
    if (en == 1'b1) begin
      case (mode)
        MODE_LOAD:   q_next = d;
        MODE_TOGGLE: q_next = q ^ t;
        MODE_JK:     q_next = (d & ~q) | (~t & q);
        MODE_UP: begin
          q_next = q + ONE;
          wrap   = (q == '1);
        end
        MODE_DOWN: begin
          q_next = q - ONE;
          wrap   = (q == '0);
        end
        MODE_SHIFT:  q_next = {q[WIDTH-2:0], sin};
        default:     q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VALUE;
      q_inverse <= ~RESET_VALUE;
      tc        <= 1'b0;
      changed   <= 1'b0;
    end else begin
      q         <= q_next;
      q_inverse <= ~q_next;
      tc        <= wrap;
      changed   <= (q_next != q);
    end
  end

endmodule

// File: tb/tb_flipflop_register_multimode.sv
// Directed self-checking bench for flipflop_register_multimode (WIDTH=4).
module tb_flipflop_register_multimode;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic [3:0] t;
  logic       sin;
  logic [3:0] q;
  logic [3:0] q_inverse;
  logic       tc;
  logic       changed;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  flipflop_register_multimode #(
    .WIDTH(4),
    .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .d(d),
    .t(t),
    .sin(sin),
    .q(q),
    .q_inverse(q_inverse),
    .tc(tc),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] eq, input logic etc, input logic ech);
    cmp({tag, ".q"}, q, eq);
    cmp({tag, ".qn"}, q_inverse, ~eq);
    cmp({tag, ".tc"}, {3'b000, tc}, {3'b000, etc});
    cmp({tag, ".changed"}, {3'b000, changed}, {3'b000, ech});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 4'h0; t = 4'h0; sin = 1'b0;
    tick(); check("reset", 4'b0000, 1'b0, 1'b0);

    rst = 1'b0; en = 1'b1; mode = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick(); check("hold", 4'b0000, 1'b0, 1'b0);
    end

    mode = 3'b001; d = 4'b1010;
    tick(); check("load", 4'b1010, 1'b0, 1'b1);
    mode = 3'b010; t = 4'b0110;
    tick(); check("toggle", 4'b1100, 1'b0, 1'b1);
    t = 4'b0000;
    tick(); check("toggle0", 4'b1100, 1'b0, 1'b0);

    mode = 3'b011; d = 4'b0011; t = 4'b0101;
    tick(); check("jk", 4'b1011, 1'b0, 1'b1);

    mode = 3'b001; d = 4'b1111;
    tick(); check("load_ones", 4'b1111, 1'b0, 1'b1);
    d = 4'b1110;
    tick(); check("load_e", 4'b1110, 1'b0, 1'b1);
    mode = 3'b100;
    tick(); check("up1", 4'b1111, 1'b0, 1'b1);
    tick(); check("up_wrap", 4'b0000, 1'b1, 1'b1);
    mode = 3'b101;
    tick(); check("down_wrap", 4'b1111, 1'b1, 1'b1);
    tick(); check("down", 4'b1110, 1'b0, 1'b1);

    mode = 3'b001; d = 4'b0000;
    tick(); check("load_zero", 4'b0000, 1'b0, 1'b1);
    tick(); check("reload_zero", 4'b0000, 1'b0, 1'b0);

    mode = 3'b110;
    sin = 1'b1; tick(); check("sh1", 4'b0001, 1'b0, 1'b1);
    sin = 1'b1; tick(); check("sh2", 4'b0011, 1'b0, 1'b1);
    sin = 1'b0; tick(); check("sh3", 4'b0110, 1'b0, 1'b1);
    sin = 1'b1; tick(); check("sh4", 4'b1101, 1'b0, 1'b1);

    en = 1'b0; mode = 3'b100;
    tick(); check("en0_a", 4'b1101, 1'b0, 1'b0);
    tick(); check("en0_b", 4'b1101, 1'b0, 1'b0);

    en = 1'b1; mode = 3'b110; sin = 1'b0;
    tick(); check("sh_msb", 4'b1010, 1'b0, 1'b1);

    mode = 3'b001; d = 4'b0110;
    tick(); check("load6", 4'b0110, 1'b0, 1'b1);
    mode = 3'b100;
    tick(); check("up7", 4'b0111, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); check("rst_mid", 4'b0000, 1'b0, 1'b0);

    rst = 1'b0; mode = 3'b001; d = 4'b0101;
    tick(); check("load5", 4'b0101, 1'b0, 1'b1);
    mode = 3'b111;
    tick(); check("reserved", 4'b0101, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
